multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Main control FSM for the multicycle MIPS datapath. It is the producer side of the ALU interface: it drives the 3-bit ALUControl code and the SrcA/SrcB operand selects.
//  It also drives the PC, instruction register, memory and register-file enables.
//  Inputs are Op/Funct from the instruction register and Zero from the ALU. Outputs are a Moore decode of the state, except PCEn.
// PARAMETERS
//  HALT_ON_ILLEGAL  0  1: unknown opcode enters HALT until reset; 0: unknown opcode returns to FETCH with no writes
// PORTS
//  clk         in   1  single clock; all state changes on posedge clk
//  reset       in   1  synchronous, active-high; state <= FETCH on the next posedge
//  Op          in   6  instruction[31:26], valid from DECODE onward
//  Funct       in   6  instruction[5:0], valid from DECODE onward
//  Zero        in   1  ALU zero flag (Result == 0)
//  IorD        out  1  memory address: 0 = PC, 1 = ALUOut
//  MemWrite    out  1  data memory write strobe
//  IRWrite     out  1  instruction register load
//  RegDst      out  1  write register: 0 = rt, 1 = rd
//  MemtoReg    out  1  write data: 0 = ALUOut, 1 = Data register
//  RegWrite    out  1  register-file write enable
//  ALUSrcA     out  2  00 = PC, 01 = A register, 10 = zero-extended shamt (instr[10:6])
//  ALUSrcB     out  2  00 = B register, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2
//  ALUControl  out  3  0 AND, 1 OR, 2 ADD, 3 SUB, 4 SLL (SrcB<<SrcA), 5 SRL, 6 SLT, 7 unused
//  PCSrc       out  2  00 = ALUResult, 01 = ALUOut, 10 = jump target
//  PCEn        out  1  PC load = PCWrite | (Branch & Zero)
//  State       out  4  current state encoding, for debug and the testbench
// BEHAVIOUR
//  State encodings:
//   FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6,
//   ALUWB=7, BEQ=8, ADDIEX=9, ADDIWB=10, JUMP=11, HALT=15.
//  Reset: State=FETCH. All outputs therefore take their FETCH values in the cycle after reset.
//   Reset has priority over every transition, including in the middle of an instruction. Writes from a partially executed instruction are dropped.
//  FETCH: IRWrite=1, ALUSrcA=00, ALUSrcB=01, ALUControl=2, PCSrc=00, PCWrite=1. Next state is DECODE.
//  DECODE: ALUSrcA=00, ALUSrcB=11, ALUControl=2 (precomputes the branch target). Next state by Op:
//   lw 100011 / sw 101011 -> MEMADR; R-type 000000 -> EXECUTE; beq 000100 -> BEQ;
//   addi 001000 -> ADDIEX; j 000010 -> JUMP; any other Op -> HALT if HALT_ON_ILLEGAL, else FETCH.
//  MEMADR: ALUSrcA=01, ALUSrcB=10, ALUControl=2. Next state is MEMRD for lw, MEMWR for sw.
//  MEMRD: IorD=1, then MEMWB. MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, then FETCH.
//  MEMWR: IorD=1, MemWrite=1, then FETCH.
//  EXECUTE: ALUSrcB=00. ALUSrcA=10 for sll/srl, otherwise 01. ALUControl comes from Funct:
//   100000->2, 100010->3, 100100->0, 100101->1, 101010->6, 000000->4, 000010->5, other->7. Next state is ALUWB.
//  ALUWB: RegDst=1, MemtoReg=0, RegWrite=1 only if Funct is recognised; an unknown Funct writes nothing. Next state is FETCH.
//  BEQ: ALUSrcA=01, ALUSrcB=00, ALUControl=3, PCSrc=01, Branch=1. PCEn=Zero in the same cycle. Next state is FETCH.
//  ADDIEX: ALUSrcA=01, ALUSrcB=10, ALUControl=2, then ADDIWB. ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1, then FETCH.
//  JUMP: PCSrc=10, PCWrite=1, then FETCH.
//  HALT: all enables 0. Stays in HALT until reset.
//  Default output values in every state: all enables 0, selects 0, ALUControl=2 (ADD). No latches.
//  Cycles per instruction, counting FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
//  Op and Funct are sampled only combinationally in DECODE, EXECUTE and ALUWB. Changes in other states have no effect.
//  Encodings 12-14 are unreachable and must recover to FETCH on the next cycle.
// TESTING
//  1. reset=1 for 2 cycles, then 0 -> State=0, IRWrite=1, PCEn=1, ALUControl=2, ALUSrcB=01.
//  2. Op=100011 -> State sequence 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4.
//  3. Op=000000 with Funct in {100000,100010,100100,100101,101010,000000,000010}
//      -> ALUControl in state 6 is {2,3,0,1,6,4,5}; ALUSrcA=10 for the two shifts only.
//  4. Op=000100: Zero=1 in state 8 -> PCEn=1, PCSrc=01. Zero=0 -> PCEn=0. Both then return to state 0.
//  5. Op=111111: HALT_ON_ILLEGAL=0 -> state 0 after DECODE. HALT_ON_ILLEGAL=1 -> state 15 held for 10 cycles; reset -> state 0.
//  6. Assert reset while in state 3 (lw) -> next State=0, and RegWrite/MemWrite never assert for that lw.

Source files
------------

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - main control FSM for the multicycle MIPS datapath
// Outputs are registered from the state being entered, so each state's decode appears with it.
module multicycle_controller #(
    parameter bit HALT_ON_ILLEGAL = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] PCSrc,
    output logic       PCEn,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BEQ     = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11,
        S_HALT    = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t     state;
    state_t     next_state;
    state_t     target;
    logic       is_store;
    logic       pc_write;
    logic       branch;
    logic [2:0] funct_alu;
    logic       funct_known;
    logic       funct_shift;

    always_comb begin
        funct_alu   = 3'd7;
        funct_known = 1'b1;
        case (Funct)
            6'b100000: funct_alu = 3'd2;
            6'b100010: funct_alu = 3'd3;
            6'b100100: funct_alu = 3'd0;
            6'b100101: funct_alu = 3'd1;
            6'b101010: funct_alu = 3'd6;
            6'b000000: funct_alu = 3'd4;
            6'b000010: funct_alu = 3'd5;
            default:   funct_known = 1'b0;
        endcase
    end

    assign funct_shift = (Funct == 6'b000000) || (Funct == 6'b000010);

    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH:   next_state = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_EXECUTE;
                    OP_BEQ:       next_state = S_BEQ;
                    OP_ADDI:      next_state = S_ADDIEX;
                    OP_J:         next_state = S_JUMP;
                    default:      next_state = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
                endcase
            end
            // lw/sw was latched in DECODE so Op is ignored from here on
            S_MEMADR:  next_state = is_store ? S_MEMWR : S_MEMRD;
            S_MEMRD:   next_state = S_MEMWB;
            S_EXECUTE: next_state = S_ALUWB;
            S_ADDIEX:  next_state = S_ADDIWB;
            S_HALT:    next_state = S_HALT;
            default:   next_state = S_FETCH;
        endcase
    end

    assign target = reset ? S_FETCH : next_state;

    always_ff @(posedge clk) begin
        state <= target;
        if (reset) begin
            is_store <= 1'b0;
        end else if (state == S_DECODE) begin
            is_store <= (Op == OP_SW);
        end

        IorD       <= 1'b0;
        MemWrite   <= 1'b0;
        IRWrite    <= 1'b0;
        RegDst     <= 1'b0;
        MemtoReg   <= 1'b0;
        RegWrite   <= 1'b0;
        ALUSrcA    <= 2'b00;
        ALUSrcB    <= 2'b00;
        ALUControl <= 3'd2;
        PCSrc      <= 2'b00;
        pc_write   <= 1'b0;
        branch     <= 1'b0;
        case (target)
            S_FETCH: begin
                IRWrite  <= 1'b1;
                ALUSrcB  <= 2'b01;
                pc_write <= 1'b1;
            end
            S_DECODE:  ALUSrcB <= 2'b11;
            S_MEMADR: begin
                ALUSrcA <= 2'b01;
                ALUSrcB <= 2'b10;
            end
            S_MEMRD:   IorD <= 1'b1;
            S_MEMWB: begin
                MemtoReg <= 1'b1;
                RegWrite <= 1'b1;
            end
            S_MEMWR: begin
                IorD     <= 1'b1;
                MemWrite <= 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA    <= funct_shift ? 2'b10 : 2'b01;
                ALUControl <= funct_alu;
            end
            S_ALUWB: begin
                RegDst   <= 1'b1;
                RegWrite <= funct_known;
            end
            S_BEQ: begin
                ALUSrcA    <= 2'b01;
                ALUControl <= 3'd3;
                PCSrc      <= 2'b01;
                branch     <= 1'b1;
            end
            S_ADDIEX: begin
                ALUSrcA <= 2'b01;
                ALUSrcB <= 2'b10;
            end
            S_ADDIWB:  RegWrite <= 1'b1;
            S_JUMP: begin
                PCSrc    <= 2'b10;
                pc_write <= 1'b1;
            end
            default: ;
        endcase
    end

    assign PCEn  = pc_write | (branch & Zero);
    assign State = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - randomized instruction stream against a per-instruction state/output model
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] Op = 6'd0;
    logic [5:0] Funct = 6'd0;
    logic       Zero = 1'b0;

    logic       iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, pc_en;
    logic [1:0] alu_src_a, alu_src_b, pc_src;
    logic [2:0] alu_control;
    logic [3:0] state;
    logic       h_iord, h_mem_write, h_ir_write, h_reg_dst, h_mem_to_reg, h_reg_write, h_pc_en;
    logic [1:0] h_alu_src_a, h_alu_src_b, h_pc_src;
    logic [2:0] h_alu_control;
    logic [3:0] h_state;

    multicycle_controller #(.HALT_ON_ILLEGAL(1'b0)) u_dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero),
        .IorD(iord), .MemWrite(mem_write), .IRWrite(ir_write), .RegDst(reg_dst),
        .MemtoReg(mem_to_reg), .RegWrite(reg_write), .ALUSrcA(alu_src_a),
        .ALUSrcB(alu_src_b), .ALUControl(alu_control), .PCSrc(pc_src),
        .PCEn(pc_en), .State(state)
    );

    multicycle_controller #(.HALT_ON_ILLEGAL(1'b1)) u_halt (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero),
        .IorD(h_iord), .MemWrite(h_mem_write), .IRWrite(h_ir_write), .RegDst(h_reg_dst),
        .MemtoReg(h_mem_to_reg), .RegWrite(h_reg_write), .ALUSrcA(h_alu_src_a),
        .ALUSrcB(h_alu_src_b), .ALUControl(h_alu_control), .PCSrc(h_pc_src),
        .PCEn(h_pc_en), .State(h_state)
    );

    logic [19:0] act, h_act;
    assign act   = {state, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                    alu_src_a, alu_src_b, alu_control, pc_src, pc_en};
    assign h_act = {h_state, h_iord, h_mem_write, h_ir_write, h_reg_dst, h_mem_to_reg, h_reg_write,
                    h_alu_src_a, h_alu_src_b, h_alu_control, h_pc_src, h_pc_en};

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int seq[$];

    localparam logic [5:0] OPS [6] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
    localparam logic [5:0] FNS [7] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000, 6'b000010};
    localparam logic [2:0] FN_ALU [7] = '{3'd2, 3'd3, 3'd0, 3'd1, 3'd6, 3'd4, 3'd5};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected {State, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, SrcA, SrcB, ALUControl, PCSrc, PCEn}
    function automatic logic [19:0] exp_vec(input int st, input logic [5:0] fn, input logic z);
        logic iord_e = 0, mw = 0, irw = 0, rd = 0, m2r = 0, rw = 0, pcen = 0;
        logic [1:0] sa = 0, sb = 0, ps = 0;
        logic [2:0] ctl = 3'd2;
        int idx = -1;
        for (int i = 0; i < 7; i++) if (FNS[i] == fn) idx = i;
        case (st)
            0:  begin irw = 1; sb = 2'b01; pcen = 1; end
            1:  sb = 2'b11;
            2:  begin sa = 2'b01; sb = 2'b10; end
            3:  iord_e = 1;
            4:  begin m2r = 1; rw = 1; end
            5:  begin iord_e = 1; mw = 1; end
            6:  begin
                    sa = (idx == 5 || idx == 6) ? 2'b10 : 2'b01;
                    ctl = (idx >= 0) ? FN_ALU[idx] : 3'd7;
                end
            7:  begin rd = 1; rw = (idx >= 0); end
            8:  begin sa = 2'b01; ctl = 3'd3; ps = 2'b01; pcen = z; end
            9:  begin sa = 2'b01; sb = 2'b10; end
            10: rw = 1;
            11: begin ps = 2'b10; pcen = 1; end
            default: ;
        endcase
        return {4'(st), iord_e, mw, irw, rd, m2r, rw, sa, sb, ctl, ps, pcen};
    endfunction

    // Instruction-level model: the state walk each opcode class takes, FETCH first
    task automatic build_seq(input logic [5:0] op);
        seq = '{0, 1};
        case (op)
            6'b100011: seq = '{0, 1, 2, 3, 4};
            6'b101011: seq = '{0, 1, 2, 5};
            6'b000000: seq = '{0, 1, 6, 7};
            6'b000100: seq = '{0, 1, 8};
            6'b001000: seq = '{0, 1, 9, 10};
            6'b000010: seq = '{0, 1, 11};
            default:   ;
        endcase
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn);
        build_seq(op);
        for (int k = 0; k < seq.size(); k++) begin
            if (k > 0) tick();
            Zero = 1'($urandom_range(0, 1));
            #1;
            check($sformatf("op%02h fn%02h st%0d", op, fn, seq[k]), act, exp_vec(seq[k], fn, Zero));
            if (seq[k] == 8) begin
                Zero = ~Zero;
                #1;
                check($sformatf("beq zero%0d", Zero), act, exp_vec(8, fn, Zero));
            end
            if (k == 0) begin
                Op = op;
                Funct = fn;
            end else if (seq[k] inside {2, 3, 5, 8, 9, 11}) begin
                Op = 6'($urandom);
                Funct = 6'($urandom);
            end
        end
        tick();
    endtask

    function automatic logic [5:0] rand_op();
        int r = $urandom_range(0, 6);
        logic [5:0] o;
        if (r < 6) return OPS[r];
        do o = 6'($urandom); while (o inside {OPS});
        return o;
    endfunction

    initial begin
        reset = 1'b1;
        tick();
        tick();
        check("reset", act, exp_vec(0, Funct, Zero));
        check("reset_halt_inst", h_act, exp_vec(0, Funct, Zero));
        reset = 1'b0;

        run_instr(6'b100011, 6'b100000);
        for (int i = 0; i < 7; i++) run_instr(6'b000000, FNS[i]);
        run_instr(6'b000000, 6'b111111);
        for (int i = 0; i < 4; i++) run_instr(6'b000100, 6'($urandom));
        run_instr(6'b111111, 6'd0);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        Op = 6'b111111;
        tick();
        check("halt_decode", 32'(h_state), 32'd1);
        tick();
        check("no_halt_fetch", 32'(state), 32'd0);
        for (int i = 0; i < 10; i++) begin
            Op = 6'($urandom);
            Zero = 1'($urandom_range(0, 1));
            #1;
            check($sformatf("halt_hold%0d", i), h_act, exp_vec(15, Funct, Zero));
            tick();
        end
        reset = 1'b1;
        tick();
        check("halt_reset", h_act, exp_vec(0, Funct, Zero));
        check("dut_reset", act, exp_vec(0, Funct, Zero));
        reset = 1'b0;

        Op = 6'b100011;
        for (int st = 1; st <= 3; st++) begin
            tick();
            check($sformatf("lw_abort st%0d", st), act, exp_vec(st, Funct, Zero));
        end
        reset = 1'b1;
        tick();
        check("lw_abort reset", act, exp_vec(0, Funct, Zero));
        check("lw_abort no write", 32'({reg_write, mem_write}), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 300; i++) begin
            logic [5:0] fn;
            fn = ($urandom_range(0, 3) != 0) ? FNS[$urandom_range(0, 6)] : 6'($urandom);
            run_instr(rand_op(), fn);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
